pll_reset_sequencer: RTL and testbench

Consumes the `locked` flag of an SB_PLL40-based clock generator and produces a clean, synchronous, active-high reset for the design running on the PLL output clock. It synchronises the asynchronous `locked` signal and requires lock to stay stable for a programmable period. It then holds reset for a further programmable period before releasing the design. On loss of lock it re-asserts reset immediately, pulses a loss event and keeps a saturating loss counter for debug (LED / UART readout).

---
 rtl/pll_reset_sequencer_if.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Bundle of the PLL lock input and the sequenced reset/status outputs.
// The sequencer drives the outputs through the master view; consumers use the slave view.
interface pll_reset_sequencer_if #(
    parameter int LOSS_CNT_W = 8
);
    logic                  locked;
    logic                  sys_reset;
    logic                  ready;
    logic                  lock_lost;
    logic [LOSS_CNT_W-1:0] loss_count;

    modport master (
        input  locked,
        output sys_reset,
        output ready,
        output lock_lost,
        output loss_count
    );

    modport slave (
        output locked,
        input  sys_reset,
        input  ready,
        input  lock_lost,
        input  loss_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Turns an asynchronous PLL lock flag into a clean synchronous reset.
// The reset is released only after lock has been stable and a hold period has elapsed.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    pll_reset_sequencer_if.master    bus
);

    localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABILIZE = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("pll_reset_sequencer: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("pll_reset_sequencer: STABLE_CYCLES must be at least 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("pll_reset_sequencer: HOLD_CYCLES must be at least 1");
    end
    if (LOSS_CNT_W < 1) begin : g_bad_loss_cnt_w
        $error("pll_reset_sequencer: LOSS_CNT_W must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  loss_event;

    logic                  sys_reset_q;
    logic                  ready_q;
    logic                  lock_lost_q;
    logic [LOSS_CNT_W-1:0] loss_count_q;

    // Shift chain that brings the asynchronous lock flag into the clock domain;
    // only the last stage is ever used for decisions.
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // A drop of locked_s is tested before the terminal count in every state,
    // so a loss on the terminating edge always returns to WAIT_LOCK.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_event = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = STABILIZE;
                end
            end

            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d    = WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    // NOTE: reset is synchronous and covers every flop, including the synchroniser chain.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_reset_q <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
            lock_lost_q <= loss_event;
            if (loss_event && !(&loss_count_q)) begin
                loss_count_q <= loss_count_q + 1'b1;
            end
        end
    end

    assign bus.sys_reset  = sys_reset_q;
    assign bus.ready      = ready_q;
    assign bus.lock_lost  = lock_lost_q;
    assign bus.loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a vector table for the main sequences,
// plus hand-written sequences for counter saturation and the terminal-count tie.
module tb_pll_reset_sequencer;

    logic clock;
    logic resetn_a;
    logic resetn_b;

    int tests_run;
    int tests_failed;

    pll_reset_sequencer_if #(.LOSS_CNT_W(2)) if_a ();
    pll_reset_sequencer_if #(.LOSS_CNT_W(8)) if_b ();

    pll_reset_sequencer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(8),
        .HOLD_CYCLES  (4),
        .LOSS_CNT_W   (2)
    ) dut_a (
        .clock (clock),
        .resetn(resetn_a),
        .bus   (if_a)
    );

    pll_reset_sequencer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(1),
        .HOLD_CYCLES  (1),
        .LOSS_CNT_W   (8)
    ) dut_b (
        .clock (clock),
        .resetn(resetn_b),
        .bus   (if_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       resetn;
        logic       locked;
        int         cycles;
        logic       sys_reset;
        logic       ready;
        logic       lock_lost;
        logic [1:0] loss_count;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic rst, input logic lk,
                                input int n, input logic sr, input logic rd,
                                input logic ll, input logic [1:0] cnt);
        vec_t v;
        v.name       = name;
        v.resetn     = rst;
        v.locked     = lk;
        v.cycles     = n;
        v.sys_reset  = sr;
        v.ready      = rd;
        v.lock_lost  = ll;
        v.loss_count = cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int exp_cnt;

        tests_run    = 0;
        tests_failed = 0;
        resetn_a     = 1'b0;
        resetn_b     = 1'b0;
        if_a.locked  = 1'b0;
        if_b.locked  = 1'b0;

        //   name           rst  lk   n   sr   rd   ll   cnt
        add("reset",        1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 2'd0);
        // Power-up release: locked first sampled at edge 1, release after edge 15.
        add("pu_idle",      1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2'd0);
        add("pu_edge14",    1'b1, 1'b1, 14, 1'b1, 1'b0, 1'b0, 2'd0);
        add("pu_edge15",    1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 2'd0);
        // Loss in RUN: sampled at edge k, reset after edge k+2, one-cycle pulse.
        add("loss1_k1",     1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 2'd0);
        add("loss1_k2",     1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 2'd1);
        add("loss1_k3",     1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2'd1);
        add("loss1_idle",   1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2'd1);
        add("relock1_e14",  1'b1, 1'b1, 14, 1'b1, 1'b0, 1'b0, 2'd1);
        add("relock1_e15",  1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 2'd1);
        add("loss2_k1",     1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 2'd1);
        add("loss2_k2",     1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 2'd2);
        add("loss2_k3",     1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2'd2);
        add("relock2_e14",  1'b1, 1'b1, 14, 1'b1, 1'b0, 1'b0, 2'd2);
        add("relock2_e15",  1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 2'd2);
        // Reset mid-RUN with loss_count=2; locked stays high throughout.
        add("midrun_rst",   1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 2'd0);
        add("midrun_e14",   1'b1, 1'b1, 14, 1'b1, 1'b0, 1'b0, 2'd0);
        add("midrun_e15",   1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 2'd0);
        // Glitch during STABILIZE: the drop lands while the counter is mid-way,
        // then the whole sequence restarts from the re-rise.
        add("glitch_rst",   1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2'd0);
        add("glitch_stab",  1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0, 2'd0);
        add("glitch_drop",  1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2'd0);
        add("glitch_e14",   1'b1, 1'b1, 14, 1'b1, 1'b0, 1'b0, 2'd0);
        add("glitch_e15",   1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            resetn_a    = vecs[i].resetn;
            if_a.locked = vecs[i].locked;
            step(vecs[i].cycles);
            check({vecs[i].name, "/sys_reset"},  if_a.sys_reset,  vecs[i].sys_reset);
            check({vecs[i].name, "/ready"},      if_a.ready,      vecs[i].ready);
            check({vecs[i].name, "/lock_lost"},  if_a.lock_lost,  vecs[i].lock_lost);
            check({vecs[i].name, "/loss_count"}, if_a.loss_count, vecs[i].loss_count);
        end

        // Saturation of the 2-bit loss counter over five lose/relock cycles.
        for (int i = 0; i < 5; i++) begin
            exp_cnt     = (i + 1 > 3) ? 3 : i + 1;
            if_a.locked = 1'b0;
            step(2);
            check($sformatf("sat%0d_pre_lock_lost", i), if_a.lock_lost, 1'b0);
            step(1);
            check($sformatf("sat%0d_lock_lost", i),  if_a.lock_lost,  1'b1);
            check($sformatf("sat%0d_sys_reset", i),  if_a.sys_reset,  1'b1);
            check($sformatf("sat%0d_loss_count", i), if_a.loss_count, exp_cnt);
            step(1);
            check($sformatf("sat%0d_pulse_end", i),  if_a.lock_lost,  1'b0);
            step(2);
            if_a.locked = 1'b1;
            step(14);
            check($sformatf("sat%0d_held", i),  if_a.sys_reset, 1'b1);
            step(1);
            check($sformatf("sat%0d_ready", i), if_a.ready,     1'b1);
        end

        // Tie on terminal count with STABLE=HOLD=1: locked high for edges 1-2,
        // low from edge 3, so locked_s drops exactly on the HOLD terminal edge 5.
        resetn_b    = 1'b0;
        if_b.locked = 1'b0;
        step(1);
        resetn_b    = 1'b1;
        if_b.locked = 1'b1;
        step(2);
        if_b.locked = 1'b0;
        step(2);
        check("tie_edge4_sys_reset", if_b.sys_reset, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("tie_edge%0d_sys_reset", 5 + i), if_b.sys_reset, 1'b1);
            check($sformatf("tie_edge%0d_lock_lost", 5 + i), if_b.lock_lost, 1'b0);
        end
        check("tie_loss_count", if_b.loss_count, 8'd0);

        // Minimum counts: a clean lock releases after edge 2+1+1+1.
        if_b.locked = 1'b1;
        step(4);
        check("min_edge4_sys_reset", if_b.sys_reset, 1'b1);
        step(1);
        check("min_edge5_sys_reset", if_b.sys_reset, 1'b0);
        check("min_edge5_ready",     if_b.ready,     1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
